snn_neuron_scheduler: RTL and testbench

Time-multiplexed leaky integrate-and-fire (LIF) controller. It shares one membrane-update datapath across N_NEURONS virtual neurons. Each timestep request triggers one round-robin pass: it reads per-neuron membrane state, applies leak and input, compares against the threshold, then resets or stores the state. It sits between the ui_in/uio_in input fabric and the uo_out spike/LED outputs of the tiny SNN top level.

---
 rtl/snn_neuron_scheduler_if.sv | 26 ++
 rtl/snn_neuron_scheduler.sv | 169 ++++++++++++++++
 tb/tb_snn_neuron_scheduler.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/snn_neuron_scheduler_if.sv
// Bus bundle for snn_neuron_scheduler: timestep request, input currents,
// threshold and debug select in; spike vector, status and debug membrane out.
interface snn_neuron_scheduler_if #(
  parameter int N_NEURONS = 4,
  parameter int IDX_W     = 2
);
  logic                   step;
  logic [8*N_NEURONS-1:0] inn_bus;
  logic [7:0]             thresh;
  logic [IDX_W-1:0]       dbg_sel;
  logic [N_NEURONS-1:0]   spikes;
  logic                   busy;
  logic                   done;
  logic [IDX_W-1:0]       cur_idx;
  logic [7:0]             v_dbg;

  modport master (
    output step, inn_bus, thresh, dbg_sel,
    input  spikes, busy, done, cur_idx, v_dbg
  );

  modport slave (
    input  step, inn_bus, thresh, dbg_sel,
    output spikes, busy, done, cur_idx, v_dbg
  );
endinterface

// File: rtl/snn_neuron_scheduler.sv
// Time-multiplexed LIF scheduler: one shared leak/integrate/fire datapath swept
// over N_NEURONS membrane registers per timestep. Optional: SNN_SCHED_REFRACTORY_EN.
module snn_neuron_scheduler #(
  parameter int N_NEURONS     = 4,
  parameter int IDX_W         = 2,
  parameter int LEAK_SHIFT    = 3,
  parameter int REFRACT_STEPS = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  snn_neuron_scheduler_if.slave  sb
);

  typedef enum logic {IDLE, UPDATE} state_t;

  localparam int IDX_SPAN = 2 ** IDX_W;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     idx;
  logic                 done_q;
  logic [N_NEURONS-1:0] spikes_q;
  logic [N_NEURONS-1:0] shadow, shadow_nxt;
  logic [7:0]           v_mem   [N_NEURONS];
  logic [7:0]           in_snap [N_NEURONS];
  logic [7:0]           thresh_snap;

  logic                 accept, upd_en, last;
  logic [7:0]           v_ext  [IDX_SPAN];
  logic [7:0]           in_ext [IDX_SPAN];
  logic [7:0]           cur_v, cur_in, leak_v, sum_v, v_new;
  logic                 refr_active, fire;

  function automatic logic [7:0] apply_leak(input logic [7:0] v);
    return v - (v >> LEAK_SHIFT);
  endfunction

  function automatic logic [7:0] sat_add_u8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  // Index-space views so any IDX_W-bit index is safe; unused slots read as 0.
  for (genvar g = 0; g < IDX_SPAN; g++) begin : g_ext
    if (g < N_NEURONS) begin : g_live
      assign v_ext[g]  = v_mem[g];
      assign in_ext[g] = in_snap[g];
    end else begin : g_pad
      assign v_ext[g]  = '0;
      assign in_ext[g] = '0;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM: next-state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sb.step) state_nxt = UPDATE;
      UPDATE:  if (last)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    accept  = 1'b0;
    upd_en  = 1'b0;
    sb.busy = 1'b0;
    case (state)
      IDLE:    accept = sb.step;
      UPDATE: begin
        upd_en  = 1'b1;
        sb.busy = 1'b1;
      end
      default: ;
    endcase
  end

  assign last   = (idx == IDX_W'(N_NEURONS - 1));
  assign cur_v  = v_ext[idx];
  assign cur_in = in_ext[idx];
  assign leak_v = apply_leak(cur_v);
  assign sum_v  = sat_add_u8(leak_v, cur_in);
  assign fire   = !refr_active && (thresh_snap != 8'd0) && (sum_v >= thresh_snap);

  always_comb begin
    v_new = sum_v;
    if (fire)             v_new = 8'd0;
    else if (refr_active) v_new = leak_v;
  end

  always_comb begin
    shadow_nxt = shadow;
    for (int i = 0; i < N_NEURONS; i++)
      if (idx == IDX_W'(i)) shadow_nxt[i] = fire;
  end

`ifdef SNN_SCHED_REFRACTORY_EN
  logic [1:0] ref_cnt [N_NEURONS];
  logic [1:0] ref_ext [IDX_SPAN];

  for (genvar g = 0; g < IDX_SPAN; g++) begin : g_ref_ext
    if (g < N_NEURONS) begin : g_live
      assign ref_ext[g] = ref_cnt[g];
    end else begin : g_pad
      assign ref_ext[g] = '0;
    end
  end

  assign refr_active = (ref_ext[idx] != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) ref_cnt[i] <= '0;
    end else if (upd_en) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        if (idx == IDX_W'(i)) begin
          if (fire)             ref_cnt[i] <= 2'(REFRACT_STEPS);
          else if (refr_active) ref_cnt[i] <= ref_cnt[i] - 2'd1;
        end
      end
    end
  end
`else
  assign refr_active = 1'b0;
`endif

  // Snapshot of inputs taken at step accept; the pass only sees these.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < N_NEURONS; i++) in_snap[i] <= sb.inn_bus[8*i +: 8];
      thresh_snap <= sb.thresh;
    end
  end

  // Update stage: one neuron per cycle, spikes published together on the last one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      done_q   <= 1'b0;
      spikes_q <= '0;
      shadow   <= '0;
      for (int i = 0; i < N_NEURONS; i++) v_mem[i] <= '0;
    end else begin
      done_q <= upd_en && last;
      if (accept) begin
        idx <= '0;
      end else if (upd_en) begin
        idx    <= last ? '0 : idx + IDX_W'(1);
        shadow <= shadow_nxt;
        for (int i = 0; i < N_NEURONS; i++)
          if (idx == IDX_W'(i)) v_mem[i] <= v_new;
        if (last) spikes_q <= shadow_nxt;
      end
    end
  end

  assign sb.done    = done_q;
  assign sb.spikes  = spikes_q;
  assign sb.cur_idx = idx;
  assign sb.v_dbg   = v_ext[sb.dbg_sel];

endmodule

// File: tb/tb_snn_neuron_scheduler.sv
// Directed bench for snn_neuron_scheduler (N=4, LEAK_SHIFT=3, REFRACT_STEPS=2).
module tb_snn_neuron_scheduler;
  logic clk;
  logic rst_n;
  int   checks;
  int   passed;

  snn_neuron_scheduler_if #(.N_NEURONS(4), .IDX_W(2)) bus ();

  snn_neuron_scheduler #(
    .N_NEURONS(4), .IDX_W(2), .LEAK_SHIFT(3), .REFRACT_STEPS(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.step = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Accept a step, then advance to just after the done edge (bounded).
  task automatic run_pass();
    int n;
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    n = 0;
    while (bus.done !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    if (bus.done !== 1'b1) begin
      checks++;
      $display("FAIL pass_timeout: done=%b after %0d cycles, required 1", bus.done, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.step = 1'b0;
    bus.inn_bus = '0;
    bus.thresh = 8'd0;
    bus.dbg_sel = 2'd0;
    #2 rst_n = 1'b0;
    tick();
    checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy); else passed++;
    checks++; if (bus.done !== 1'b0) $display("FAIL rst_done: got %b want 0", bus.done); else passed++;
    checks++; if (bus.spikes !== 4'b0000) $display("FAIL rst_spikes: got %b want 0000", bus.spikes); else passed++;
    checks++; if (bus.cur_idx !== 2'd0) $display("FAIL rst_idx: got %0d want 0", bus.cur_idx); else passed++;
    checks++; if (bus.v_dbg !== 8'd0) $display("FAIL rst_v0: got %0d want 0", bus.v_dbg); else passed++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_integrate_fire();
    bus.thresh = 8'd100;
    bus.inn_bus = {8'd0, 8'd0, 8'd0, 8'd60};
    bus.dbg_sel = 2'd0;
    run_pass();
    checks++; if (bus.spikes !== 4'b0000) $display("FAIL if_p1_spikes: got %b want 0000", bus.spikes); else passed++;
    checks++; if (bus.v_dbg !== 8'd60) $display("FAIL if_p1_v0: got %0d want 60", bus.v_dbg); else passed++;
    run_pass();
    checks++; if (bus.spikes !== 4'b0001) $display("FAIL if_p2_spikes: got %b want 0001", bus.spikes); else passed++;
    checks++; if (bus.v_dbg !== 8'd0) $display("FAIL if_p2_v0: got %0d want 0", bus.v_dbg); else passed++;
    run_pass();
    checks++; if (bus.spikes !== 4'b0000) $display("FAIL if_p3_spikes: got %b want 0000", bus.spikes); else passed++;
    checks++; if (bus.v_dbg !== 8'd60) $display("FAIL if_p3_v0: got %0d want 60", bus.v_dbg); else passed++;
    bus.dbg_sel = 2'd1;
    #1;
    checks++; if (bus.v_dbg !== 8'd0) $display("FAIL if_p3_v1: got %0d want 0", bus.v_dbg); else passed++;
  endtask

  // Starts in the done cycle of the previous pass with v0=60, in0=60, thresh=100.
  task automatic test_latency();
    bus.step = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus.busy !== 1'b1) $display("FAIL lat_busy_%0d: got %b want 1", k, bus.busy); else passed++;
      checks++; if (bus.cur_idx !== 2'(k)) $display("FAIL lat_idx_%0d: got %0d want %0d", k, bus.cur_idx, k); else passed++;
      checks++; if (bus.done !== 1'b0) $display("FAIL lat_done_%0d: got %b want 0", k, bus.done); else passed++;
      checks++; if (bus.spikes !== 4'b0000) $display("FAIL lat_spk_%0d: got %b want 0000", k, bus.spikes); else passed++;
      bus.step = 1'b0;
      tick();
    end
    checks++; if (bus.busy !== 1'b0) $display("FAIL lat_end_busy: got %b want 0", bus.busy); else passed++;
    checks++; if (bus.done !== 1'b1) $display("FAIL lat_end_done: got %b want 1", bus.done); else passed++;
    checks++; if (bus.spikes !== 4'b0001) $display("FAIL lat_end_spikes: got %b want 0001", bus.spikes); else passed++;
    tick();
    checks++; if (bus.done !== 1'b0) $display("FAIL lat_done_drop: got %b want 0", bus.done); else passed++;
    checks++; if (bus.cur_idx !== 2'd0) $display("FAIL lat_idle_idx: got %0d want 0", bus.cur_idx); else passed++;
    tick();
    checks++; if (bus.spikes !== 4'b0001) $display("FAIL lat_spk_hold: got %b want 0001", bus.spikes); else passed++;
  endtask

  task automatic test_saturation();
    apply_reset();
    bus.thresh = 8'd0;
    bus.inn_bus = {8'd0, 8'd0, 8'd255, 8'd0};
    bus.dbg_sel = 2'd1;
    run_pass();
    checks++; if (bus.v_dbg !== 8'd255) $display("FAIL sat_p1_v1: got %0d want 255", bus.v_dbg); else passed++;
    checks++; if (bus.spikes !== 4'b0000) $display("FAIL sat_p1_spikes: got %b want 0000", bus.spikes); else passed++;
    run_pass();
    checks++; if (bus.v_dbg !== 8'd255) $display("FAIL sat_p2_v1: got %0d want 255", bus.v_dbg); else passed++;
    checks++; if (bus.spikes !== 4'b0000) $display("FAIL sat_p2_spikes: got %b want 0000", bus.spikes); else passed++;
  endtask

  task automatic test_ignored_step();
    int dones;
    apply_reset();
    bus.thresh = 8'd0;
    bus.inn_bus = '0;
    bus.dbg_sel = 2'd2;
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    dones = 0;
    for (int k = 1; k < 14; k++) begin
      if (k == 1) begin
        bus.step = 1'b1;
        bus.inn_bus = {8'd0, 8'd200, 8'd0, 8'd0};
      end
      if (k == 3) bus.step = 1'b0;
      tick();
      if (bus.done === 1'b1) dones++;
    end
    checks++; if (dones != 1) $display("FAIL ign_done_count: got %0d want 1", dones); else passed++;
    checks++; if (bus.v_dbg !== 8'd0) $display("FAIL ign_v2: got %0d want 0", bus.v_dbg); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL ign_busy: got %b want 0", bus.busy); else passed++;
  endtask

  task automatic test_reset_mid_pass();
    int dones;
    apply_reset();
    bus.thresh = 8'd50;
    bus.inn_bus = {8'd0, 8'd0, 8'd10, 8'd60};
    bus.dbg_sel = 2'd1;
    run_pass();
    checks++; if (bus.spikes !== 4'b0001) $display("FAIL rmp_pre_spikes: got %b want 0001", bus.spikes); else passed++;
    checks++; if (bus.v_dbg !== 8'd10) $display("FAIL rmp_pre_v1: got %0d want 10", bus.v_dbg); else passed++;
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) $display("FAIL rmp_busy: got %b want 0", bus.busy); else passed++;
    checks++; if (bus.spikes !== 4'b0000) $display("FAIL rmp_spikes: got %b want 0000", bus.spikes); else passed++;
    checks++; if (bus.cur_idx !== 2'd0) $display("FAIL rmp_idx: got %0d want 0", bus.cur_idx); else passed++;
    checks++; if (bus.v_dbg !== 8'd0) $display("FAIL rmp_v1: got %0d want 0", bus.v_dbg); else passed++;
    bus.dbg_sel = 2'd0;
    #1;
    checks++; if (bus.v_dbg !== 8'd0) $display("FAIL rmp_v0: got %0d want 0", bus.v_dbg); else passed++;
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.done === 1'b1) dones++;
    end
    checks++; if (dones != 0) $display("FAIL rmp_no_done: got %0d pulses want 0", dones); else passed++;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    bus.thresh = 8'd100;
    bus.inn_bus = {8'd0, 8'd0, 8'd0, 8'd60};
    bus.dbg_sel = 2'd0;
    run_pass();
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    checks++; if (bus.busy !== 1'b1) $display("FAIL b2b_busy: got %b want 1", bus.busy); else passed++;
    checks++; if (bus.cur_idx !== 2'd0) $display("FAIL b2b_idx: got %0d want 0", bus.cur_idx); else passed++;
    for (int k = 0; k < 4; k++) tick();
    checks++; if (bus.done !== 1'b1) $display("FAIL b2b_done: got %b want 1", bus.done); else passed++;
    checks++; if (bus.spikes !== 4'b0001) $display("FAIL b2b_spikes: got %b want 0001", bus.spikes); else passed++;
  endtask

  task automatic test_refractory();
    logic [3:0] exp_fire;
`ifdef SNN_SCHED_REFRACTORY_EN
    exp_fire = 4'b1001;
`else
    exp_fire = 4'b1111;
`endif
    apply_reset();
    bus.thresh = 8'd50;
    bus.inn_bus = {8'd0, 8'd0, 8'd0, 8'd60};
    bus.dbg_sel = 2'd0;
    for (int p = 0; p < 4; p++) begin
      run_pass();
      checks++;
      if (bus.spikes !== {3'b000, exp_fire[p]})
        $display("FAIL refr_p%0d_spikes: got %b want %b", p + 1, bus.spikes, {3'b000, exp_fire[p]});
      else passed++;
      checks++; if (bus.v_dbg !== 8'd0) $display("FAIL refr_p%0d_v0: got %0d want 0", p + 1, bus.v_dbg); else passed++;
    end
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_integrate_fire();
    test_latency();
    test_saturation();
    test_ignored_step();
    test_reset_mid_pass();
    test_back_to_back();
    test_refractory();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
